// File: rtl/ide_host.sv
`default_nettype none
// ============================================================================
// ide_host -- PIO taskfile host for LBA28 READ/WRITE SECTORS with a word
// buffer port, BSY/DRQ/ERR status polling and a poll-phase timeout.
// Revision: 1.0
// ============================================================================
module ide_host #(
    parameter logic [23:0] TIMEOUT = 24'd1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic        cmd_write,
    input  logic [27:0] cmd_lba,
    input  logic [7:0]  cmd_count,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] buf_addr,
    output logic [15:0] buf_wdata,
    output logic        buf_we,
    input  logic [15:0] buf_rdata,
    output logic        ide_sel,
    output logic        ide_we,
    output logic [2:0]  ide_reg,
    output logic [15:0] ide_dat_o,
    input  logic [15:0] ide_dat_i
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        CMD     = 3'd2,
        POLL    = 3'd3,
        XFER_RD = 3'd4,
        XFER_WR = 3'd5,
        FINISH  = 3'd6
    } state_t;

    state_t      state, state_n;
    logic [27:0] lba, lba_n;
    logic        wr, wr_n;
    logic [7:0]  sectors_left, sectors_left_n;
    logic [7:0]  sec_idx, sec_idx_n;
    logic [7:0]  word_idx, word_idx_n;
    logic [2:0]  step, step_n;
    logic [1:0]  phase, phase_n;
    logic [23:0] tmo, tmo_n;

    logic        busy_n, done_n, error_n, buf_we_n;
    logic [15:0] buf_addr_n, buf_wdata_n;
    logic        ide_sel_n, ide_we_n;
    logic [2:0]  ide_reg_n;
    logic [15:0] ide_dat_o_n;
    logic [7:0]  setup_byte;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            lba          <= 28'd0;
            wr           <= 1'b0;
            sectors_left <= 8'd0;
            sec_idx      <= 8'd0;
            word_idx     <= 8'd0;
            step         <= 3'd0;
            phase        <= 2'd0;
            tmo          <= 24'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            buf_we       <= 1'b0;
            buf_addr     <= 16'd0;
            buf_wdata    <= 16'd0;
            ide_sel      <= 1'b0;
            ide_we       <= 1'b0;
            ide_reg      <= 3'd0;
            ide_dat_o    <= 16'd0;
        end else begin
            state        <= state_n;
            lba          <= lba_n;
            wr           <= wr_n;
            sectors_left <= sectors_left_n;
            sec_idx      <= sec_idx_n;
            word_idx     <= word_idx_n;
            step         <= step_n;
            phase        <= phase_n;
            tmo          <= tmo_n;
            busy         <= busy_n;
            done         <= done_n;
            error        <= error_n;
            buf_we       <= buf_we_n;
            buf_addr     <= buf_addr_n;
            buf_wdata    <= buf_wdata_n;
            ide_sel      <= ide_sel_n;
            ide_we       <= ide_we_n;
            ide_reg      <= ide_reg_n;
            ide_dat_o    <= ide_dat_o_n;
        end
    end

    // Taskfile bytes for registers 2..6; sectors_left still equals the count here.
    always_comb begin
        case (step)
            3'd0:    setup_byte = sectors_left;
            3'd1:    setup_byte = lba[7:0];
            3'd2:    setup_byte = lba[15:8];
            3'd3:    setup_byte = lba[23:16];
            default: setup_byte = {4'hE, lba[27:24]};
        endcase
    end

    always_comb begin
        state_n        = state;
        lba_n          = lba;
        wr_n           = wr;
        sectors_left_n = sectors_left;
        sec_idx_n      = sec_idx;
        word_idx_n     = word_idx;
        step_n         = step;
        phase_n        = phase;
        tmo_n          = tmo;
        busy_n         = busy;
        done_n         = 1'b0;
        error_n        = error;
        buf_we_n       = 1'b0;
        buf_addr_n     = buf_addr;
        buf_wdata_n    = buf_wdata;
        ide_sel_n      = 1'b0;
        ide_we_n       = ide_we;
        ide_reg_n      = ide_reg;
        ide_dat_o_n    = ide_dat_o;

        case (state)
            IDLE: begin
                if (cmd_start) begin
                    busy_n         = 1'b1;
                    lba_n          = cmd_lba;
                    wr_n           = cmd_write;
                    sectors_left_n = cmd_count;
                    sec_idx_n      = 8'd0;
                    word_idx_n     = 8'd0;
                    step_n         = 3'd0;
                    phase_n        = 2'd0;
                    if (cmd_count != 8'd0) begin
                        error_n = 1'b0;
                        state_n = SETUP;
                    end else begin
                        error_n = 1'b1;
                        state_n = FINISH;
                    end
                end
            end

            SETUP: begin
                if (!ide_sel) begin
                    ide_sel_n   = 1'b1;
                    ide_we_n    = 1'b1;
                    ide_reg_n   = 3'd2 + step;
                    ide_dat_o_n = {8'h00, setup_byte};
                end else if (step == 3'd4) begin
                    state_n = CMD;
                end else begin
                    step_n = step + 3'd1;
                end
            end

            CMD: begin
                if (!ide_sel) begin
                    ide_sel_n   = 1'b1;
                    ide_we_n    = 1'b1;
                    ide_reg_n   = 3'd7;
                    ide_dat_o_n = wr ? 16'h0030 : 16'h0020;
                end else begin
                    state_n = POLL;
                    tmo_n   = 24'd0;
                end
            end

            POLL: begin
                tmo_n = tmo + 24'd1;
                if (tmo_n >= TIMEOUT) begin
                    state_n = FINISH;
                    error_n = 1'b1;
                end else if (!ide_sel) begin
                    ide_sel_n = 1'b1;
                    ide_we_n  = 1'b0;
                    ide_reg_n = 3'd7;
                end else if (ide_dat_i[7]) begin
                    state_n = POLL;
                end else if (ide_dat_i[0]) begin
                    state_n = FINISH;
                    error_n = 1'b1;
                end else if (ide_dat_i[3]) begin
                    word_idx_n = 8'd0;
                    phase_n    = 2'd0;
                    if (wr) begin
                        state_n    = XFER_WR;
                        buf_addr_n = {sec_idx, 8'd0};
                    end else begin
                        state_n = XFER_RD;
                    end
                end else begin
                    state_n = FINISH;
                    error_n = (sectors_left != 8'd0);
                end
            end

            XFER_RD: begin
                if (!ide_sel) begin
                    ide_sel_n = 1'b1;
                    ide_we_n  = 1'b0;
                    ide_reg_n = 3'd0;
                end else begin
                    buf_we_n    = 1'b1;
                    buf_wdata_n = ide_dat_i;
                    buf_addr_n  = {sec_idx, word_idx};
                    word_idx_n  = word_idx + 8'd1;
                    if (word_idx == 8'hFF) begin
                        sec_idx_n      = sec_idx + 8'd1;
                        sectors_left_n = sectors_left - 8'd1;
                        state_n        = POLL;
                        tmo_n          = 24'd0;
                    end
                end
            end

            // Phase 0 shows the address, phase 1 sees buf_rdata, phase 2 is the bus write.
            XFER_WR: begin
                case (phase)
                    2'd0: phase_n = 2'd1;
                    2'd1: begin
                        ide_sel_n   = 1'b1;
                        ide_we_n    = 1'b1;
                        ide_reg_n   = 3'd0;
                        ide_dat_o_n = buf_rdata;
                        phase_n     = 2'd2;
                    end
                    default: begin
                        phase_n    = 2'd0;
                        word_idx_n = word_idx + 8'd1;
                        if (word_idx == 8'hFF) begin
                            sec_idx_n      = sec_idx + 8'd1;
                            sectors_left_n = sectors_left - 8'd1;
                            state_n        = POLL;
                            tmo_n          = 24'd0;
                        end else begin
                            buf_addr_n = {sec_idx, word_idx + 8'd1};
                        end
                    end
                endcase
            end

            FINISH: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end

            default: state_n = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ide_host.sv
`default_nettype none
// tb_ide_host: randomized bench with a behavioural PIO device, a synchronous
// word buffer and an event log compared against expected command traffic.
module tb_ide_host;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_start = 1'b0, cmd_write = 1'b0;
    logic [27:0] cmd_lba = 28'd0;
    logic [7:0]  cmd_count = 8'd0;
    logic        busy, done, error, buf_we, ide_sel, ide_we;
    logic [15:0] buf_addr, buf_wdata, buf_rdata, ide_dat_o, ide_dat_i;
    logic [2:0]  ide_reg;

    ide_host #(.TIMEOUT(24'd100)) dut (
        .clk(clk), .reset(reset),
        .cmd_start(cmd_start), .cmd_write(cmd_write), .cmd_lba(cmd_lba), .cmd_count(cmd_count),
        .busy(busy), .done(done), .error(error),
        .buf_addr(buf_addr), .buf_wdata(buf_wdata), .buf_we(buf_we), .buf_rdata(buf_rdata),
        .ide_sel(ide_sel), .ide_we(ide_we), .ide_reg(ide_reg),
        .ide_dat_o(ide_dat_o), .ide_dat_i(ide_dat_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  k;
        logic [2:0]  r;
        logic [15:0] d;
        logic [31:0] c;
    } ev_t;
    localparam logic [1:0] EV_TF = 2'd0, EV_WR0 = 2'd1, EV_RD0 = 2'd2, EV_STAT = 2'd3;

    int checks = 0, failures = 0;
    int cyc = 0, start_cyc = 0;
    ev_t         ev_log[$];
    logic [31:0] we_log[$];
    logic [15:0] buf_mem [0:65535];

    int          dev_busy_cfg = 0;
    bit          dev_force_en = 1'b0;
    logic [7:0]  dev_force = 8'h00;
    logic [15:0] dev_base = 16'h0000;
    int          dev_busy_left = 0, dev_sectors_left = 0, dev_sec = 0, dev_word = 0;
    logic [7:0]  dev_count_reg = 8'd0;
    int          cmd_cyc = 0, status_cyc = 0, rd_total = 0, proto_err = 0;
    logic        prev_sel = 1'b0;

    function automatic int pick_busy();
        return (dev_busy_cfg >= 0) ? dev_busy_cfg : int'($urandom_range(0, 3));
    endfunction

    // Taskfile write sequence a command must produce, excluding data-register traffic.
    function automatic logic [18:0] tf_expect(input int i, input bit wr, input logic [27:0] lba,
                                              input logic [7:0] cnt);
        case (i)
            0:       return {3'd2, 8'h00, cnt};
            1:       return {3'd3, 8'h00, lba[7:0]};
            2:       return {3'd4, 8'h00, lba[15:8]};
            3:       return {3'd5, 8'h00, lba[23:16]};
            4:       return {3'd6, 8'h00, 4'hE, lba[27:24]};
            default: return {3'd7, (wr ? 16'h0030 : 16'h0020)};
        endcase
    endfunction

    always_comb begin
        ide_dat_i = 16'hDEAD;
        if (ide_reg == 3'd7) begin
            if (dev_force_en)              ide_dat_i = {8'h00, dev_force};
            else if (dev_busy_left > 0)    ide_dat_i = 16'h0080;
            else if (dev_sectors_left > 0) ide_dat_i = 16'h0008;
            else                           ide_dat_i = 16'h0040;
        end else if (ide_reg == 3'd0) begin
            ide_dat_i = dev_base + 16'(dev_sec * 256 + dev_word);
        end
    end

    always @(posedge clk) buf_rdata <= buf_mem[buf_addr];

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        prev_sel <= ide_sel;
        if (prev_sel && ide_sel) proto_err <= proto_err + 1;
        if (buf_we) we_log.push_back({buf_addr, buf_wdata});
        if (ide_sel && ide_we && ide_reg != 3'd0) begin
            ev_log.push_back('{EV_TF, ide_reg, ide_dat_o, cyc});
            if (ide_reg == 3'd2) dev_count_reg <= ide_dat_o[7:0];
            if (ide_reg == 3'd7) begin
                cmd_cyc          <= cyc;
                dev_sectors_left <= int'(dev_count_reg);
                dev_sec          <= 0;
                dev_word         <= 0;
                dev_busy_left    <= pick_busy();
            end
        end else if (ide_sel && ide_reg == 3'd0) begin
            ev_log.push_back('{(ide_we ? EV_WR0 : EV_RD0), ide_reg, (ide_we ? ide_dat_o : ide_dat_i), cyc});
            if (!ide_we) rd_total <= rd_total + 1;
            if (dev_word == 255) begin
                dev_word         <= 0;
                dev_sec          <= dev_sec + 1;
                dev_sectors_left <= dev_sectors_left - 1;
                dev_busy_left    <= pick_busy();
            end else begin
                dev_word <= dev_word + 1;
            end
        end else if (ide_sel && ide_reg == 3'd7) begin
            ev_log.push_back('{EV_STAT, ide_reg, ide_dat_i, cyc});
            status_cyc <= cyc;
            if (dev_busy_left > 0) dev_busy_left <= dev_busy_left - 1;
        end
    end

    task automatic start_cmd(input bit wr, input logic [27:0] lba, input logic [7:0] cnt);
        @(negedge clk);
        cmd_start = 1'b1; cmd_write = wr; cmd_lba = lba; cmd_count = cnt; start_cyc = cyc;
        @(negedge clk);
        cmd_start = 1'b0; cmd_write = 1'($urandom); cmd_lba = 28'($urandom); cmd_count = 8'($urandom);
    endtask

    task automatic wait_done(input int limit, output bit ok, output int dcyc);
        ok = 1'b0; dcyc = -1;
        for (int i = 0; i < limit && !ok; i++) begin
            if (done) begin ok = 1'b1; dcyc = cyc; end
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        checks++; if ({busy, done, error, buf_we, ide_sel, ide_we} !== 6'b0) begin
            failures++; $display("FAIL reset_ctrl got %b expected 000000", {busy, done, error, buf_we, ide_sel, ide_we}); end
        checks++; if ({ide_reg, ide_dat_o} !== 19'd0) begin
            failures++; $display("FAIL reset_bus got reg=%0d dat=%h expected 0/0000", ide_reg, ide_dat_o); end
        checks++; if ({buf_addr, buf_wdata} !== 32'd0) begin
            failures++; $display("FAIL reset_buf got addr=%h wdata=%h expected 0000/0000", buf_addr, buf_wdata); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if ({ide_sel, buf_we, busy} !== 3'b000) begin
            failures++; $display("FAIL reset_release got sel/we/busy=%b expected 000", {ide_sel, buf_we, busy}); end
    endtask

    task automatic test_read_basic();
        int snap_ev, snap_we, n, nstat, dcyc; bit ok, seen_rd;
        logic [27:0] lba = 28'h0123456;
        dev_busy_cfg = 3; dev_base = 16'h1000; dev_force_en = 1'b0;
        snap_ev = ev_log.size(); snap_we = we_log.size();
        start_cmd(1'b0, lba, 8'd1);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rd_busy got %b expected 1", busy); end
        wait_done(3000, ok, dcyc);
        checks++; if (!ok) begin failures++; $display("FAIL rd_done got no done expected done"); end
        checks++; if ({error, busy} !== 2'b00) begin
            failures++; $display("FAIL rd_status got error/busy=%b expected 00", {error, busy}); end
        n = 0; nstat = 0; seen_rd = 1'b0;
        for (int j = snap_ev; j < ev_log.size(); j++) begin
            if (ev_log[j].k == EV_RD0) seen_rd = 1'b1;
            if (ev_log[j].k == EV_STAT && !seen_rd) nstat++;
            if (ev_log[j].k == EV_TF) begin
                checks++;
                if ({ev_log[j].r, ev_log[j].d} !== tf_expect(n, 1'b0, lba, 8'd1)) begin
                    failures++; $display("FAIL rd_taskfile[%0d] got reg%0d=%h expected %h", n, ev_log[j].r, ev_log[j].d, tf_expect(n, 1'b0, lba, 8'd1)); end
                n++;
            end
        end
        checks++; if (n !== 6) begin failures++; $display("FAIL rd_taskfile_count got %0d expected 6", n); end
        checks++; if (nstat !== 4) begin failures++; $display("FAIL rd_polls got %0d expected 4", nstat); end
        checks++; if (we_log.size() - snap_we !== 256) begin
            failures++; $display("FAIL rd_we_count got %0d expected 256", we_log.size() - snap_we); end
        for (int e = 0; e < 256 && snap_we + e < we_log.size(); e++) begin
            checks++;
            if (we_log[snap_we + e] !== {16'(e), 16'h1000 + 16'(e)}) begin
                failures++; $display("FAIL rd_word[%0d] got %h expected %h", e, we_log[snap_we + e], {16'(e), 16'h1000 + 16'(e)}); end
        end
    endtask

    task automatic test_write_two_sectors();
        int snap_ev, snap_we, n, nrd, dcyc; bit ok, mid_poll;
        for (int a = 0; a < 512; a++) buf_mem[a] = 16'(a);
        dev_busy_cfg = -1; dev_force_en = 1'b0;
        snap_ev = ev_log.size(); snap_we = we_log.size();
        start_cmd(1'b1, 28'($urandom), 8'd2);
        wait_done(5000, ok, dcyc);
        checks++; if (!ok || error !== 1'b0) begin
            failures++; $display("FAIL wr_done got ok=%0d error=%b expected 1/0", ok, error); end
        n = 0; nrd = 0; mid_poll = 1'b0;
        for (int j = snap_ev; j < ev_log.size(); j++) begin
            if (ev_log[j].k == EV_RD0) nrd++;
            if (ev_log[j].k == EV_STAT && n == 256) mid_poll = 1'b1;
            if (ev_log[j].k == EV_WR0) begin
                checks++;
                if (ev_log[j].d !== 16'(n)) begin
                    failures++; $display("FAIL wr_word[%0d] got %h expected %h", n, ev_log[j].d, 16'(n)); end
                n++;
            end
        end
        checks++; if (n !== 512) begin failures++; $display("FAIL wr_count got %0d expected 512", n); end
        checks++; if (!mid_poll) begin failures++; $display("FAIL wr_mid_poll got none expected status read"); end
        checks++; if (nrd !== 0 || we_log.size() !== snap_we) begin
            failures++; $display("FAIL wr_no_reads got rd=%0d we=%0d expected 0/0", nrd, we_log.size() - snap_we); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int snap_ev, snap_we, n, ntf, nwr, dcyc; bit ok, wr;
            logic [27:0] lba; logic [7:0] cnt;
            wr = 1'($urandom); lba = 28'($urandom); cnt = 8'($urandom_range(1, 3));
            dev_busy_cfg = -1; dev_base = 16'($urandom); dev_force_en = 1'b0;
            for (int a = 0; a < int'(cnt) * 256; a++) buf_mem[a] = 16'($urandom);
            snap_ev = ev_log.size(); snap_we = we_log.size();
            start_cmd(wr, lba, cnt);
            wait_done(8000, ok, dcyc);
            checks++; if (!ok || error !== 1'b0) begin
                failures++; $display("FAIL rnd%0d_done got ok=%0d error=%b expected 1/0", it, ok, error); end
            ntf = 0; nwr = 0;
            for (int j = snap_ev; j < ev_log.size(); j++) begin
                if (ev_log[j].k == EV_TF) begin
                    checks++;
                    if ({ev_log[j].r, ev_log[j].d} !== tf_expect(ntf, wr, lba, cnt)) begin
                        failures++; $display("FAIL rnd%0d_taskfile[%0d] got reg%0d=%h expected %h", it, ntf, ev_log[j].r, ev_log[j].d, tf_expect(ntf, wr, lba, cnt)); end
                    ntf++;
                end else if (ev_log[j].k == EV_WR0) begin
                    checks++;
                    if (!wr || ev_log[j].d !== buf_mem[nwr]) begin
                        failures++; $display("FAIL rnd%0d_wrword[%0d] got %h expected %h", it, nwr, ev_log[j].d, buf_mem[nwr]); end
                    nwr++;
                end
            end
            n = we_log.size() - snap_we;
            checks++; if (ntf !== 6 || n + nwr !== int'(cnt) * 256 || (wr ? n : nwr) !== 0) begin
                failures++; $display("FAIL rnd%0d_counts got tf=%0d we=%0d wr0=%0d expected 6 and %0d words", it, ntf, n, nwr, int'(cnt) * 256); end
            for (int e = 0; e < n; e++) begin
                checks++;
                if (we_log[snap_we + e] !== {16'(e), dev_base + 16'(e)}) begin
                    failures++; $display("FAIL rnd%0d_rdword[%0d] got %h expected %h", it, e, we_log[snap_we + e], {16'(e), dev_base + 16'(e)}); end
            end
        end
    endtask

    task automatic test_status_error();
        int snap_ev, n0, dcyc; bit ok;
        dev_force_en = 1'b1; dev_force = 8'h41;
        snap_ev = ev_log.size();
        start_cmd(1'($urandom), 28'($urandom), 8'($urandom_range(1, 5)));
        wait_done(500, ok, dcyc);
        checks++; if (!ok || error !== 1'b1) begin
            failures++; $display("FAIL err_done got ok=%0d error=%b expected 1/1", ok, error); end
        checks++; if (dcyc - status_cyc < 1 || dcyc - status_cyc > 4) begin
            failures++; $display("FAIL err_latency got %0d expected 1..4", dcyc - status_cyc); end
        n0 = 0;
        for (int j = snap_ev; j < ev_log.size(); j++)
            if (ev_log[j].k == EV_RD0 || ev_log[j].k == EV_WR0) n0++;
        checks++; if (n0 !== 0) begin failures++; $display("FAIL err_no_data got %0d expected 0", n0); end
        dev_force_en = 1'b0;
    endtask

    task automatic test_timeout();
        int dcyc; bit ok;
        dev_force_en = 1'b1; dev_force = 8'h80;
        start_cmd(1'b0, 28'($urandom), 8'd1);
        wait_done(400, ok, dcyc);
        checks++; if (!ok || error !== 1'b1) begin
            failures++; $display("FAIL tmo_done got ok=%0d error=%b expected 1/1", ok, error); end
        checks++; if (dcyc - (cmd_cyc + 1) < 98 || dcyc - (cmd_cyc + 1) > 102) begin
            failures++; $display("FAIL tmo_latency got %0d expected 98..102", dcyc - (cmd_cyc + 1)); end
        checks++; if (ide_sel !== 1'b0) begin failures++; $display("FAIL tmo_sel got %b expected 0", ide_sel); end
        dev_force_en = 1'b0;
    endtask

    task automatic test_zero_count();
        int snap_ev, s;
        snap_ev = ev_log.size();
        @(negedge clk);
        cmd_start = 1'b1; cmd_count = 8'd0; cmd_write = 1'($urandom); cmd_lba = 28'($urandom); s = cyc;
        @(negedge clk);
        cmd_count = 8'd5;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL zero_busy got %b expected 1", busy); end
        @(negedge clk);
        cmd_start = 1'b0;
        checks++; if ({done, error, busy} !== 3'b110 || cyc - s !== 2) begin
            failures++; $display("FAIL zero_done got done/err/busy=%b at +%0d expected 110 at +2", {done, error, busy}, cyc - s); end
        repeat (20) @(negedge clk);
        checks++; if (ev_log.size() !== snap_ev || busy !== 1'b0 || error !== 1'b1) begin
            failures++; $display("FAIL zero_ignored got events=%0d busy=%b error=%b expected 0/0/1", ev_log.size() - snap_ev, busy, error); end
    endtask

    task automatic test_reset_mid();
        int snap_rd, snap_we, dcyc; bit ok, reached;
        dev_busy_cfg = 0; dev_base = 16'($urandom); dev_force_en = 1'b0;
        snap_rd = rd_total;
        start_cmd(1'b0, 28'($urandom), 8'd1);
        reached = 1'b0;
        for (int i = 0; i < 1000 && !reached; i++) begin
            if (rd_total - snap_rd >= 100) reached = 1'b1;
            else @(negedge clk);
        end
        checks++; if (!reached) begin failures++; $display("FAIL mid_reach got %0d reads expected 100", rd_total - snap_rd); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({ide_sel, busy, buf_we} !== 3'b000) begin
            failures++; $display("FAIL mid_reset got sel/busy/we=%b expected 000", {ide_sel, busy, buf_we}); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        snap_we = we_log.size();
        start_cmd(1'b0, 28'($urandom), 8'd1);
        wait_done(3000, ok, dcyc);
        checks++; if (!ok || error !== 1'b0 || we_log.size() - snap_we !== 256) begin
            failures++; $display("FAIL mid_restart got ok=%0d error=%b words=%0d expected 1/0/256", ok, error, we_log.size() - snap_we); end
        for (int e = 0; e < 256 && snap_we + e < we_log.size(); e++) begin
            checks++;
            if (we_log[snap_we + e] !== {16'(e), dev_base + 16'(e)}) begin
                failures++; $display("FAIL mid_word[%0d] got %h expected %h", e, we_log[snap_we + e], {16'(e), dev_base + 16'(e)}); end
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_two_sectors();
        test_random();
        test_status_error();
        test_timeout();
        test_zero_count();
        test_reset_mid();
        repeat (2) @(negedge clk);
        checks++; if (proto_err !== 0) begin failures++; $display("FAIL bus_protocol got %0d back-to-back selects expected 0", proto_err); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ide_host.md
IDE_HOST -- requirements
Module: ide_host

Interface
REQ-001 SHALL have parameter TIMEOUT, default 24'd1000000, maximum cycles spent in one status-poll phase before abort.
REQ-002 SHALL have ports, one per line:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- cmd_start  in  1  one-cycle request, sampled in IDLE only.
- cmd_write  in  1  0 = READ SECTORS (0x20), 1 = WRITE SECTORS (0x30); sampled with cmd_start.
- cmd_lba  in  28  LBA28 start address; sampled with cmd_start.
- cmd_count  in  8  sector count, 1..255; sampled with cmd_start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- error  out  1  status of last command; valid with done, held until next accepted start.
- buf_addr  out  16  {sector_index[7:0], word_index[7:0]}.
- buf_wdata  out  16  word read from device.
- buf_we  out  1  buffer write strobe (read commands).
- buf_rdata  in  16  buffer word, valid one cycle after buf_addr.
- ide_sel  out  1  device register access strobe.
- ide_we  out  1  1 = write access.
- ide_reg  out  3  taskfile register index.
- ide_dat_o  out  16  write data to device.
- ide_dat_i  in  16  read data from device, valid while ide_sel high.

Function
REQ-003 Every bus access SHALL be ide_sel high exactly one cycle followed by at least one cycle low; ide_reg/ide_we/ide_dat_o stable during the high cycle.
REQ-004 Read data SHALL be captured from ide_dat_i at the clock edge ending the ide_sel-high cycle.
REQ-005 States SHALL be IDLE, SETUP, CMD, POLL, XFER_RD, XFER_WR, FINISH.
REQ-006 IDLE: cmd_start with cmd_count != 0 -> latch inputs, busy=1, error=0, go SETUP; cmd_count == 0 -> FINISH with error=1, no bus access.
REQ-007 SETUP SHALL write, in order: reg2 = count, reg3 = lba[7:0], reg4 = lba[15:8], reg5 = lba[23:16], reg6 = {4'hE, lba[27:24]}; each value on ide_dat_o[7:0], ide_dat_o[15:8] = 0.
REQ-008 CMD SHALL write reg7 = 0x20 or 0x30, then go POLL with timeout counter cleared.
REQ-009 POLL SHALL read reg7 repeatedly; status bits: BSY = [7], DRQ = [3], ERR = [0].
REQ-010 POLL decision, in priority order:
- BSY=1 -> poll again.
- ERR=1 -> FINISH, error=1.
- DRQ=1 -> XFER_RD or XFER_WR per direction.
- sectors_left == 0 -> FINISH, error=0.
- otherwise -> FINISH, error=1.
REQ-011 The timeout counter SHALL increment every POLL cycle; reaching TIMEOUT -> FINISH with error=1 and ide_sel low.
REQ-012 XFER_RD SHALL perform 256 reads of reg0; each captured word drives buf_wdata with buf_we high for one cycle at buf_addr = {sector_index, word_index}; 2 cycles per word.
REQ-013 XFER_WR SHALL per word present buf_addr one cycle, then write reg0 with ide_dat_o = buf_rdata, then one idle cycle; 3 cycles per word.
REQ-014 After word 255: sector_index += 1, sectors_left -= 1, word_index wraps to 0, go POLL with timeout counter cleared.
REQ-015 FINISH SHALL pulse done for one cycle, drop busy in the same cycle, and return to IDLE.
REQ-016 cmd_start while busy SHALL be ignored; inputs change only the latched copy on acceptance.
REQ-017 sector_index SHALL start at 0 per command and never exceed cmd_count-1 on buf_addr.

Reset
REQ-018 Reset SHALL force IDLE and set busy, done, error, buf_we, ide_sel, ide_we to 0, and ide_reg, ide_dat_o, buf_addr, buf_wdata to 0, immediately (asynchronously), including mid-transfer.
REQ-019 No bus or buffer access SHALL occur in the cycle reset deasserts.

Verification
REQ-020 Read lba=0x0123456, count=1; device model returns status 0x80 x3 then 0x08, data i -> 0x1000+i -> taskfile writes 01,56,34,12,E0,20 in order; 256 buf_we at buf_addr 0x0000..0x00FF with data 0x1000..0x10FF; final status 0x40 -> done, error=0.
REQ-021 Write, count=2, buffer word = address -> 512 reg0 writes with data 0x0000..0x00FF, 0x0100..0x01FF; POLL between sectors; done, error=0.
REQ-022 Status 0x41 after command -> done within 4 cycles of the capture, error=1, no reg0 access.
REQ-023 Status held at 0x80, TIMEOUT=100 -> done at 100 +/- 2 cycles after POLL entry, error=1.
REQ-024 cmd_count=0 -> done two cycles after start, error=1, ide_sel never high; second cmd_start during busy -> ignored.
REQ-025 Assert reset on word 100 of a read -> ide_sel and busy low immediately; subsequent cmd_start restarts at buf_addr 0x0000.
